fc_argmax: RTL and testbench

FC_ARGMAX -- requirements
Module: fc_argmax

---
 rtl/fc_argmax_pkg.sv | 13 +
 rtl/fc_argmax.sv | 93 +++++++++
 tb/tb_fc_argmax.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fc_argmax_pkg.sv
// Shared defaults and state encoding for the fc score argmax block.
package fc_argmax_pkg;

  localparam int NUM_CLASS_DEF = 10;
  localparam int DW_DEF        = 32;
  localparam int IDX_W_DEF     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/fc_argmax.sv
// Streaming argmax over one frame of NUM_CLASS signed fc scores.
// state   | meaning
// IDLE    | no score of the current frame received yet (count 0)
// SCAN    | frame partially received (count 1..NUM_CLASS-1)
module fc_argmax
  import fc_argmax_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF,
  parameter int DW        = DW_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ivalid,
  input  logic signed [DW-1:0] din,
  input  logic                 clear,
  output logic                 ovalid,
  output logic [IDX_W-1:0]     class_idx,
  output logic signed [DW-1:0] max_val,
  output logic                 busy
);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     cnt, cnt_nxt;
  logic signed [DW-1:0] run_max, run_max_nxt;
  logic [IDX_W-1:0]     run_idx, run_idx_nxt;
  logic [IDX_W-1:0]     class_idx_nxt;
  logic signed [DW-1:0] max_val_nxt;
  logic                 ovalid_nxt;

  logic                 take_new;
  logic                 last;
  logic signed [DW-1:0] cur_max;
  logic [IDX_W-1:0]     cur_idx;

  // Index of the incoming score equals cnt (0 in IDLE), so one select covers both states.
  assign take_new = (state == ST_IDLE) || (din > run_max);
  assign cur_max  = take_new ? din : run_max;
  assign cur_idx  = take_new ? cnt : run_idx;
  assign last     = (cnt == IDX_W'(NUM_CLASS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      class_idx <= '0;
      max_val   <= '0;
      ovalid    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      run_max   <= run_max_nxt;
      run_idx   <= run_idx_nxt;
      class_idx <= class_idx_nxt;
      max_val   <= max_val_nxt;
      ovalid    <= ovalid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    run_max_nxt   = run_max;
    run_idx_nxt   = run_idx;
    class_idx_nxt = class_idx;
    max_val_nxt   = max_val;
    ovalid_nxt    = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (ivalid) begin
      run_max_nxt = cur_max;
      run_idx_nxt = cur_idx;
      if (last) begin
        state_nxt     = ST_IDLE;
        cnt_nxt       = '0;
        class_idx_nxt = cur_idx;
        max_val_nxt   = cur_max;
        ovalid_nxt    = 1'b1;
      end else begin
        state_nxt = ST_SCAN;
        cnt_nxt   = cnt + IDX_W'(1);
      end
    end
  end

  always_comb begin
    busy = (state == ST_SCAN);
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Randomized and directed checks of fc_argmax against a frame-level argmax model.
module tb_fc_argmax;

  localparam int N = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ivalid = 1'b0;
  logic signed [31:0] din = '0;
  logic               clear = 1'b0;
  logic               ovalid;
  logic [3:0]         class_idx;
  logic signed [31:0] max_val;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: scores of the frame in progress plus the last completed result.
  int     frame_q[$];
  bit     exp_valid = 0;
  longint exp_idx   = 0;
  longint exp_max   = 0;
  int     pulses[$];

  fc_argmax #(.NUM_CLASS(N), .DW(32), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .din(din), .clear(clear),
    .ovalid(ovalid), .class_idx(class_idx), .max_val(max_val), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_accept(input int d);
    int best;
    frame_q.push_back(d);
    if (frame_q.size() == N) begin
      best = 0;
      for (int i = 1; i < N; i++)
        if (frame_q[i] > frame_q[best]) best = i;
      exp_idx   = best;
      exp_max   = frame_q[best];
      exp_valid = 1;
      frame_q.delete();
    end
  endtask

  task automatic step(input bit v, input int d, input bit c = 0, input bit r = 0);
    longint mv;
    ivalid = v; din = d; clear = c; rst = r;
    @(posedge clk);
    exp_valid = 0;
    if (r) begin
      frame_q.delete();
      exp_idx = 0;
      exp_max = 0;
    end else if (c) begin
      frame_q.delete();
    end else if (v) begin
      model_accept(d);
    end
    @(negedge clk);
    cyc++;
    mv = max_val;
    chk("ovalid", longint'(ovalid), longint'(exp_valid));
    chk("class_idx", longint'(class_idx), exp_idx);
    chk("max_val", mv, exp_max);
    chk("busy", longint'(busy), longint'(frame_q.size() != 0));
    if (ovalid) pulses.push_back(cyc);
  endtask

  initial begin
    int mn, mx, v;
    mn = 32'h8000_0000;
    mx = 32'h7fff_ffff;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0);

    // ascending 0..9
    for (int i = 0; i < N; i++) step(1, i);
    step(0, 0);

    // all ties with gaps
    for (int i = 0; i < N; i++) begin
      step(1, 5);
      step(0, int'($urandom));
    end

    // negative frame then extreme values
    for (int i = 0; i < N; i++) step(1, -100 - i);
    for (int i = 0; i < N; i++) step(1, (i == 3) ? mx : mn);
    step(0, 0);

    // clear mid-frame with ivalid high
    pulses.delete();
    for (int i = 0; i < 5; i++) step(1, (i == 2) ? 50 : i);
    step(1, 99, 1);
    for (int i = 0; i < N; i++) step(1, (i == 6) ? 7 : i - 3);
    step(0, 0);
    chk("clear_pulses", pulses.size(), 1);

    // back-to-back frames
    pulses.delete();
    for (int i = 0; i < 2 * N; i++) step(1, (i < N) ? ((i == 4) ? 1000 : i) : ((i == 17) ? -3 : -10 - i));
    step(0, 0);
    chk("b2b_pulses", pulses.size(), 2);
    if (pulses.size() == 2) chk("b2b_spacing", pulses[1] - pulses[0], N);

    // reset mid-frame
    for (int i = 0; i < 4; i++) step(1, 100 + i);
    step(1, 500, 0, 1);
    for (int i = 0; i < N; i++) step(1, i);
    step(0, 0);

    // random frames with gaps and occasional clears
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 2))
        0: v = int'($urandom);
        1: v = int'($urandom_range(0, 7)) - 4;
        default: v = ($urandom_range(0, 1) != 0) ? mn : mx;
      endcase
      step($urandom_range(0, 2) != 0, v, $urandom_range(0, 59) == 0);
    end
    step(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
